// File: rtl/cache_write_scheduler_pkg.sv
// Shared port indices, default widths and small helpers for the cache write scheduler.
// Used by the top level and by the reusable rr_arbiter4.
package cache_write_scheduler_pkg;

    localparam int NUM_PORTS          = 4;
    localparam int PORT_NORTH         = 0;
    localparam int PORT_SOUTH         = 1;
    localparam int PORT_EAST          = 2;
    localparam int PORT_WEST          = 3;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    typedef logic [1:0] port_idx_t;

    // Encode a one-hot (or zero) port vector; zero maps to the north port.
    function automatic port_idx_t onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        port_idx_t idx;
        idx = port_idx_t'(PORT_NORTH);
        unique case (oh)
            4'b0010: idx = port_idx_t'(PORT_SOUTH);
            4'b0100: idx = port_idx_t'(PORT_EAST);
            4'b1000: idx = port_idx_t'(PORT_WEST);
            default: idx = port_idx_t'(PORT_NORTH);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/cache_write_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first requester found scanning
// ptr, ptr+1, ... mod 4. Purely combinational and reusable for router outputs.
module rr_arbiter4
    import cache_write_scheduler_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_PORTS-1:0] grant
);

    port_idx_t scan_idx;
    logic      found;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_idx = ptr + port_idx_t'(k);
            if (!found && req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_write_scheduler.sv
// Round-robin write scheduler: four router ports share one cache-bank write port via a FIFO.
// Optional read-after-write hazard detection is enabled with `define CACHE_WSCHED_HAZARD_EN.
module cache_write_scheduler
    import cache_write_scheduler_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            wrReq,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] wrAddr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wrData,
    output logic [NUM_PORTS-1:0]            wrGrant,
    output logic                            cacheWrite,
    output logic [ADDR_WIDTH-1:0]           cacheWriteAddr,
    output logic [DATA_WIDTH-1:0]           cacheWriteData,
    input  logic                            cacheReady,
    output logic [PTR_WIDTH:0]              fifoCount,
    output logic                            fifoFull,
    output logic                            fifoEmpty,
    input  logic [ADDR_WIDTH-1:0]           rdAddr,
    output logic                            rdHazard
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]    count_q,  count_d;
    port_idx_t             rr_ptr_q, rr_ptr_d;

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

    logic [NUM_PORTS-1:0]  arb_grant;
    logic [NUM_PORTS-1:0]  grant;
    port_idx_t             grant_idx;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0] push_data;

    rr_arbiter4 u_arb (
        .req   (wrReq),
        .ptr   (rr_ptr_q),
        .grant (arb_grant)
    );

    // A full FIFO blocks grants even when a pop happens this cycle; the slot frees next cycle.
    always_comb begin
        full      = (count_q == FULL_COUNT);
        empty     = (count_q == '0);
        grant     = (reset || full) ? '0 : arb_grant;
        grant_idx = onehot_to_idx(grant);
        push      = |grant;
        pop       = !empty && cacheReady;
        push_addr = wrAddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        push_data = wrData[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
            rr_ptr_d = grant_idx + port_idx_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Storage carries no reset; push is already suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= push_addr;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        wrGrant        = grant;
        cacheWrite     = !empty;
        cacheWriteAddr = empty ? '0 : addr_mem_q[rd_ptr_q];
        cacheWriteData = empty ? '0 : data_mem_q[rd_ptr_q];
        fifoCount      = count_q;
        fifoFull       = full;
        fifoEmpty      = empty;
    end

`ifdef CACHE_WSCHED_HAZARD_EN
    logic [PTR_WIDTH-1:0] entry_offset;
    logic                 hazard;

    // An entry is live when its distance from the head is below the stored count.
    always_comb begin
        hazard       = 1'b0;
        entry_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_offset = PTR_WIDTH'(i) - rd_ptr_q;
            if (({1'b0, entry_offset} < count_q) && (addr_mem_q[i] == rdAddr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign rdHazard = hazard;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rdAddr;
    assign rdHazard       = 1'b0;
`endif

endmodule

// File: tb/tb_cache_write_scheduler.sv
// Directed bench for cache_write_scheduler: arbitration order, FIFO fill/drain,
// wrap-around, mid-run reset and the optional hazard output.
module tb_cache_write_scheduler;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef CACHE_WSCHED_HAZARD_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      wrReq;
    logic [4*AW-1:0] wrAddr;
    logic [4*DW-1:0] wrData;
    logic [3:0]      wrGrant;
    logic            cacheWrite;
    logic [AW-1:0]   cacheWriteAddr;
    logic [DW-1:0]   cacheWriteData;
    logic            cacheReady;
    logic [2:0]      fifoCount;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [AW-1:0]   rdAddr;
    logic            rdHazard;

    int n_total = 0;
    int n_pass  = 0;

    cache_write_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .wrReq          (wrReq),
        .wrAddr         (wrAddr),
        .wrData         (wrData),
        .wrGrant        (wrGrant),
        .cacheWrite     (cacheWrite),
        .cacheWriteAddr (cacheWriteAddr),
        .cacheWriteData (cacheWriteData),
        .cacheReady     (cacheReady),
        .fifoCount      (fifoCount),
        .fifoFull       (fifoFull),
        .fifoEmpty      (fifoEmpty),
        .rdAddr         (rdAddr),
        .rdHazard       (rdHazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrAddr[p*AW +: AW] = a;
        wrData[p*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        wrReq      = 4'b0000;
        cacheReady = 1'b0;
        tick();
        reset      = 1'b0;
    endtask

    initial begin
        int mcount;
        int sent;
        int rcv;
        logic ready;

        reset      = 1'b1;
        wrReq      = 4'b0000;
        wrAddr     = '0;
        wrData     = '0;
        cacheReady = 1'b0;
        rdAddr     = 8'h00;
        tick();
        tick();
        #1;
        chk("rst_cacheWrite", 64'(cacheWrite), 64'd0);
        chk("rst_empty",      64'(fifoEmpty),  64'd1);
        chk("rst_full",       64'(fifoFull),   64'd0);
        chk("rst_count",      64'(fifoCount),  64'd0);
        chk("rst_grant",      64'(wrGrant),    64'd0);
        chk("rst_hazard",     64'(rdHazard),   64'd0);
        chk("rst_addr",       64'(cacheWriteAddr), 64'd0);
        chk("rst_data",       64'(cacheWriteData), 64'd0);
        reset = 1'b0;

        // Single write
        tick();
        set_port(0, 8'h10, 32'hDEADBEEF);
        wrReq = 4'b0001;
        cacheReady = 1'b1;
        #1;
        chk("single_grant", 64'(wrGrant), 64'h1);
        chk("single_nobypass", 64'(cacheWrite), 64'd0);
        tick();
        wrReq = 4'b0000;
        #1;
        chk("single_cw",    64'(cacheWrite), 64'd1);
        chk("single_addr",  64'(cacheWriteAddr), 64'h10);
        chk("single_data",  64'(cacheWriteData), 64'hDEADBEEF);
        chk("single_count", 64'(fifoCount), 64'd1);
        tick();
        #1;
        chk("single_empty", 64'(fifoEmpty), 64'd1);

        // All four ports requesting, drained every cycle
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 8'(8'h20 + p), 32'(32'hA0 + p));
        cacheReady = 1'b1;
        wrReq = 4'b1111;
        #1;
        chk("rr_g0", 64'(wrGrant), 64'b0001);
        tick();
        wrReq = 4'b1110;
        #1;
        chk("rr_g1", 64'(wrGrant), 64'b0010);
        chk("rr_h0", 64'(cacheWriteAddr), 64'h20);
        tick();
        wrReq = 4'b1100;
        #1;
        chk("rr_g2", 64'(wrGrant), 64'b0100);
        chk("rr_h1", 64'(cacheWriteAddr), 64'h21);
        tick();
        wrReq = 4'b1000;
        #1;
        chk("rr_g3", 64'(wrGrant), 64'b1000);
        chk("rr_h2", 64'(cacheWriteAddr), 64'h22);
        tick();
        wrReq = 4'b0000;
        #1;
        chk("rr_g_none", 64'(wrGrant), 64'b0000);
        chk("rr_h3",     64'(cacheWriteAddr), 64'h23);
        chk("rr_h3_data", 64'(cacheWriteData), 64'hA3);
        chk("rr_count",  64'(fifoCount), 64'd1);
        tick();
        wrReq = 4'b0011;
        #1;
        chk("rr_ptr_wrapped", 64'(wrGrant), 64'b0001);
        chk("rr_drained", 64'(fifoEmpty), 64'd1);
        wrReq = 4'b0000;

        // Fill with bank stalled, then free one slot
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 8'(8'h30 + p), 32'(32'hB0 + p));
        wrReq = 4'b1111;
        #1;
        chk("fill_g0", 64'(wrGrant), 64'b0001);
        tick();
        wrReq = 4'b1110;
        #1;
        chk("fill_g1", 64'(wrGrant), 64'b0010);
        tick();
        wrReq = 4'b1100;
        #1;
        chk("fill_g2", 64'(wrGrant), 64'b0100);
        tick();
        wrReq = 4'b1000;
        #1;
        chk("fill_g3", 64'(wrGrant), 64'b1000);
        tick();
        set_port(0, 8'h34, 32'hB4);
        wrReq = 4'b0001;
        #1;
        chk("fill_full",  64'(fifoFull),  64'd1);
        chk("fill_count", 64'(fifoCount), 64'd4);
        chk("fill_block", 64'(wrGrant),   64'b0000);
        chk("fill_head",  64'(cacheWriteAddr), 64'h30);
        tick();
        cacheReady = 1'b1;
        #1;
        chk("fill_hold_head", 64'(cacheWriteAddr), 64'h30);
        chk("full_pop_nogrant", 64'(wrGrant), 64'b0000);
        tick();
        cacheReady = 1'b0;
        #1;
        chk("fill_count3", 64'(fifoCount), 64'd3);
        chk("fill_regrant", 64'(wrGrant), 64'b0001);
        tick();
        wrReq = 4'b0000;
        #1;
        chk("fill_count4", 64'(fifoCount), 64'd4);
        cacheReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_drain_addr", 64'(cacheWriteAddr), 64'(8'h31 + k));
            chk("fill_drain_data", 64'(cacheWriteData), 64'(32'hB1 + k));
            tick();
        end
        #1;
        chk("fill_empty", 64'(fifoEmpty), 64'd1);

        // Wrap-around: ten writes from the east port with the bank ready every other cycle
        do_reset();
        mcount = 0;
        sent   = 0;
        rcv    = 0;
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            ready      = (c % 2 == 0);
            cacheReady = ready;
            wrReq      = (sent < 10) ? 4'b0100 : 4'b0000;
            set_port(2, 8'(8'h50 + sent), 32'(32'hC0 + sent));
            #1;
            chk("wrap_grant", 64'(wrGrant), (sent < 10 && mcount < 4) ? 64'b0100 : 64'b0000);
            chk("wrap_cw",    64'(cacheWrite), 64'(mcount > 0));
            if (mcount > 0 && ready) begin
                chk("wrap_data", 64'(cacheWriteData), 64'(32'hC0 + rcv));
                rcv++;
                mcount--;
            end
            if (sent < 10 && mcount + ((mcount > 0 || !ready) ? 0 : 0) < 4 && wrGrant != 4'b0000) begin
                sent++;
                mcount++;
            end
            tick();
        end
        wrReq = 4'b0000;
        #1;
        chk("wrap_all_received", 64'(rcv), 64'd10);
        chk("wrap_final_count",  64'(fifoCount), 64'd0);

        // Reset in the middle of traffic
        do_reset();
        wrReq = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_port(0, 8'(8'h60 + k), 32'(32'hD0 + k));
            tick();
        end
        wrReq = 4'b0000;
        #1;
        chk("mid_count3", 64'(fifoCount), 64'd3);
        reset = 1'b1;
        wrReq = 4'b0011;
        #1;
        chk("mid_rst_grant", 64'(wrGrant), 64'b0000);
        tick();
        reset = 1'b0;
        wrReq = 4'b0000;
        #1;
        chk("mid_cw",    64'(cacheWrite), 64'd0);
        chk("mid_count", 64'(fifoCount),  64'd0);
        wrReq = 4'b0011;
        #1;
        chk("mid_north_first", 64'(wrGrant), 64'b0001);
        wrReq = 4'b0000;

        // Hazard detection
        do_reset();
        set_port(0, 8'h22, 32'hE0);
        rdAddr = 8'h22;
        wrReq = 4'b0001;
        #1;
        chk("hz_push_excluded", 64'(rdHazard), 64'd0);
        tick();
        wrReq = 4'b0000;
        #1;
        chk("hz_pending", 64'(rdHazard), 64'(HZ));
        rdAddr = 8'h23;
        #1;
        chk("hz_other_addr", 64'(rdHazard), 64'd0);
        rdAddr = 8'h22;
        cacheReady = 1'b1;
        #1;
        chk("hz_before_pop", 64'(rdHazard), 64'(HZ));
        tick();
        #1;
        chk("hz_drained", 64'(rdHazard), 64'd0);
        chk("hz_empty",   64'(fifoEmpty), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_write_scheduler.md
Name: cache_write_scheduler

Overview:
Shares the single cache-bank write port between the four router input ports (N=0, S=1, E=2, W=3). Each cycle a round-robin arbiter grants at most one write request, and the granted request is pushed into a write FIFO. The FIFO drains to the cache bank over a valid/ready handshake, one write per accepted cycle. It sits between the router input ports and the cache bank, replacing ad-hoc per-cycle write muxing.

Parameters:
ADDR_WIDTH, 8, cache bank address width (matches `CACHE_BANK_ADDRESS_WIDTH)
DATA_WIDTH, 32, write data width (matches `DATA_WIDTH)
DEPTH, 4, FIFO entries; power of 2, ≥2
PTR_WIDTH, $clog2(DEPTH), read/write pointer width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high
wrReq  in  4  per-port write request, bit i = port i; held until granted
wrAddr  in  4*ADDR_WIDTH  port i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
wrData  in  4*DATA_WIDTH  port i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
wrGrant  out  4  one-hot or zero; combinational; request accepted at this posedge
cacheWrite  out  1  FIFO head valid (write to bank)
cacheWriteAddr  out  ADDR_WIDTH  head address
cacheWriteData  out  DATA_WIDTH  head data
cacheReady  in  1  bank accepts the write this cycle
fifoCount  out  PTR_WIDTH+1  stored entries, 0..DEPTH
fifoFull  out  1  fifoCount == DEPTH
fifoEmpty  out  1  fifoCount == 0
rdAddr  in  ADDR_WIDTH  read address to check (hazard feature only)
rdHazard  out  1  pending write to rdAddr (hazard feature only)

Behaviour:
- Reset values (first posedge with reset=1): count=0, wrPtr=rdPtr=0, rrPtr=0. Outputs cacheWrite=0, fifoEmpty=1, fifoFull=0, fifoCount=0, wrGrant=0, rdHazard=0. addr/data outputs are 0. FIFO contents are don't-care.
- Grant (combinational): if fifoFull, wrGrant=0. Otherwise grant the first requesting port scanning rrPtr, rrPtr+1, … mod 4.
- Round-robin update: on a grant to port g, rrPtr <= (g+1) mod 4. With no grant, rrPtr holds.
- Push: on a grant, mem[wrPtr] <= port g addr/data and wrPtr <= wrPtr+1 (wraps mod DEPTH).
- Pop: cacheWrite = !fifoEmpty, and addr/data = mem[rdPtr]. A transfer occurs at the posedge where cacheWrite && cacheReady, then rdPtr <= rdPtr+1 (wraps).
- Count: +1 push only, −1 pop only, unchanged on both or neither.
- Full with pop in the same cycle: no grant. There is no same-cycle credit; the freed slot is usable next cycle.
- Empty: no bypass. A pushed write appears on cacheWrite the cycle after the push. Minimum latency from grant to bank write is 1 cycle.
- Ordering: bank writes occur in grant order.
- cacheReady low: head and outputs hold stable until a transfer.
- Reset mid-operation: all pending writes are discarded. Any wrGrant asserted in the reset cycle is ignored, with no push.
- A requester whose wrReq is dropped before grant is never granted.

Optional Feature:
- Macro: CACHE_WSCHED_HAZARD_EN.
- Defined: rdHazard = 1 combinationally when any stored valid entry (rdPtr..wrPtr−1, count entries) has address == rdAddr. The entry being pushed this cycle is excluded.
- Undefined: rdHazard is tied to 0, rdAddr is unused, and no comparators are built.

Decomposition:
- Shared package/header (globalVariables.v): port index constants PORT_NORTH..PORT_WEST = 0..3 and the default widths.
- One sub-module, rr_arbiter4: inputs req[3:0] and ptr[1:0], output one-hot grant[3:0]. It is reusable for router output arbitration.
- FIFO storage and pointers stay inline.

Test Plan:
- Single write: after reset, wrReq=0001, addr 0x10, data 0xDEADBEEF, cacheReady=1. Expect wrGrant=0001 that cycle. Next cycle cacheWrite=1 with 0x10/0xDEADBEEF. Following cycle fifoEmpty=1.
- All four requesting and held, cacheReady=1: grants are 0001, 0010, 0100, 1000 on consecutive cycles. Bank sees addrs N,S,E,W in that order. rrPtr=0 at end.
- Fill with cacheReady=0, DEPTH=4: 4 grants, then fifoFull=1 and wrGrant=0 while wrReq≠0. Raise cacheReady in a cycle with wrReq held: count goes 4→3 with no grant that cycle, then the next grant brings it back to 4.
- Wrap-around: 10 writes with cacheReady toggling 1/0. Expect all 10 data words in order and the final count=0.
- Reset mid-operation: count=3, assert reset 1 cycle. Next cycle cacheWrite=0, count=0, rrPtr=0, and a new N request is granted first.
- Hazard (macro on): pending write to 0x22, rdAddr=0x22 gives rdHazard=1. After it drains, rdHazard=0. With rdAddr=0x23, rdHazard=0 throughout. With the macro off, rdHazard=0 always.
